cond_logic: RTL and testbench
=============================

// Module: cond_logic
// PURPOSE
//   Conditional-execution stage directly downstream of the instruction decoder.
//   Holds the architectural NZCV flag register and evaluates the instruction's
//   Cond field against the current flags. Gates the decoder's PCS/RegW/MemW
//   strobes so that a failed condition writes nothing. Counts executed and
//   squashed instructions for debug.
// PARAMETERS
//   CNT_W   32   width of the executed/squashed instruction counters
// PORTS
//   clk          in   1      system clock; all state updates on rising edge
//   reset        in   1      synchronous, active-high reset
//   en           in   1      instruction valid this cycle (low = stall/bubble)
//   Cond         in   4      instruction condition field, Instr[31:28]
//   ALUFlags     in   4      {N,Z,C,V} produced by the ALU this cycle
//   FlagW        in   2      from decoder: [1] update N,Z; [0] update C,V
//   PCS          in   1      from decoder: PC-source strobe
//   RegW         in   1      from decoder: register-write strobe
//   MemW         in   1      from decoder: memory-write strobe
//   PCSrc        out  1      gated PCS
//   RegWrite     out  1      gated RegW
//   MemWrite     out  1      gated MemW
//   CondEx       out  1      condition passed (combinational)
//   Flags        out  4      registered {N,Z,C,V}
//   exec_cnt     out  CNT_W  instructions with en=1 and CondEx=1
//   squash_cnt   out  CNT_W  instructions with en=1 and CondEx=0
// BEHAVIOUR
//   - Reset: Flags=4'b0000, exec_cnt=0, squash_cnt=0. Reset takes priority over
//     en at the same edge; a mid-instruction reset discards that instruction's
//     flag update and count.
//   - CondEx is evaluated from the registered Flags (the pre-instruction flags),
//     never from ALUFlags: EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C;
//     MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V; HI 1000 C&!Z;
//     LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V);
//     LE 1101 Z|(N!=V); AL 1110 1; 1111 -> 0 (unimplemented, treated as never).
//   - Outputs PCSrc/RegWrite/MemWrite = strobe & CondEx & en; zero latency.
//   - Flag update at the clock edge when en & CondEx & !reset:
//     FlagW[1] -> Flags[3:2] <= ALUFlags[3:2];
//     FlagW[0] -> Flags[1:0] <= ALUFlags[1:0].
//     The two halves are independent; unselected bits hold. New flags become
//     visible to CondEx in the following cycle only.
//   - en=0: no flag update, no counter change, all gated strobes 0;
//     CondEx still reflects Cond vs Flags.
//   - Counters: exec_cnt increments when en&CondEx, and squash_cnt increments
//     when en&!CondEx. Exactly one counter increments per valid instruction.
//     Both counters wrap modulo 2^CNT_W (all-ones -> 0) with no sticky flag.
// TESTING
//   1 reset=1 with en=1, Cond=1110, FlagW=11, ALUFlags=1111 -> Flags stays 0000,
//     counters 0.
//   2 Cond=1110, FlagW=10, ALUFlags=0100, en=1 -> next cycle Flags=0100.
//     Then Cond=0000, RegW=1 -> RegWrite=1, exec_cnt=2.
//   3 Flags=0100, Cond=0001, MemW=1, FlagW=11, ALUFlags=1011 -> MemWrite=0,
//     Flags unchanged at 0100, squash_cnt+1.
//   4 Sweep all 16 Cond codes against all 16 Flags values -> CondEx matches the
//     table in BEHAVIOUR; Cond=1111 always gives 0.
//   5 Flags=0000, Cond=1110, FlagW=01, ALUFlags=1111 -> Flags=0011 (N,Z held).
//     In the same cycle en=0 -> no update, PCSrc=0.
//   6 Force exec_cnt to all-ones with CNT_W=4; one more executed instruction ->
//     exec_cnt=0 and squash_cnt unchanged.

Source files
------------

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - conditional-execution stage: NZCV flags, condition check, strobe gating, counters
//
// Holds the architectural NZCV flag register, evaluates the instruction's
// condition field against the flags held before the instruction, gates the
// decoder's write strobes on the result, and counts executed and squashed
// instructions.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   en                    instruction valid this cycle
//   Cond[3:0]             instruction condition field
//   ALUFlags[3:0]         {N,Z,C,V} from the ALU this cycle
//   FlagW[1:0]            [1] update N,Z; [0] update C,V
//   PCS, RegW, MemW       decoder strobes
//   PCSrc, RegWrite,
//   MemWrite              strobes gated by en and CondEx
//   CondEx                condition passed (combinational)
//   Flags[3:0]            registered {N,Z,C,V}
//   exec_cnt, squash_cnt  executed / squashed instruction counts (wrapping)

module cond_logic #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] exec_cnt,
   output logic [CNT_W-1:0] squash_cnt
);

   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
   logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

   logic flag_n, flag_z, flag_c, flag_v;
   logic cond_base;

   assign flag_n = flags_q[3];
   assign flag_z = flags_q[2];
   assign flag_c = flags_q[1];
   assign flag_v = flags_q[0];

   // Condition codes come in complementary pairs: Cond[3:1] picks the base
   // test and Cond[0] inverts it. The 111x pair has base "always", so 1110
   // passes and 1111 (unimplemented) never does.
   always_comb begin
      cond_base = 1'b0;
      case (Cond[3:1])
         3'b000:  cond_base = flag_z;
         3'b001:  cond_base = flag_c;
         3'b010:  cond_base = flag_n;
         3'b011:  cond_base = flag_v;
         3'b100:  cond_base = flag_c & ~flag_z;
         3'b101:  cond_base = (flag_n == flag_v);
         3'b110:  cond_base = ~flag_z & (flag_n == flag_v);
         default: cond_base = 1'b1;
      endcase
   end

   assign CondEx   = cond_base ^ Cond[0];
   assign PCSrc    = PCS  & CondEx & en;
   assign RegWrite = RegW & CondEx & en;
   assign MemWrite = MemW & CondEx & en;

   always_comb begin
      flags_d      = flags_q;
      exec_cnt_d   = exec_cnt_q;
      squash_cnt_d = squash_cnt_q;
      if (en) begin
         if (CondEx) begin
            exec_cnt_d = exec_cnt_q + CNT_W'(1);
            if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
         end else begin
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q      <= 4'b0000;
         exec_cnt_q   <= '0;
         squash_cnt_q <= '0;
      end else begin
         flags_q      <= flags_d;
         exec_cnt_q   <= exec_cnt_d;
         squash_cnt_q <= squash_cnt_d;
      end
   end

   assign Flags      = flags_q;
   assign exec_cnt   = exec_cnt_q;
   assign squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - directed self-checking bench for cond_logic

module tb_cond_logic;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic [3:0]       Cond;
   logic [3:0]       ALUFlags;
   logic [1:0]       FlagW;
   logic             PCS, RegW, MemW;
   logic             PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0]       Flags;
   logic [CNT_W-1:0] exec_cnt, squash_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [CNT_W-1:0] exp_exec, exp_squash;

   cond_logic #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .Cond       (Cond),
      .ALUFlags   (ALUFlags),
      .FlagW      (FlagW),
      .PCS        (PCS),
      .RegW       (RegW),
      .MemW       (MemW),
      .PCSrc      (PCSrc),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .CondEx     (CondEx),
      .Flags      (Flags),
      .exec_cnt   (exec_cnt),
      .squash_cnt (squash_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference condition table, written out code by code.
   function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'b0000: return z;
         4'b0001: return !z;
         4'b0010: return cf;
         4'b0011: return !cf;
         4'b0100: return n;
         4'b0101: return !n;
         4'b0110: return v;
         4'b0111: return !v;
         4'b1000: return cf && !z;
         4'b1001: return !cf || z;
         4'b1010: return n == v;
         4'b1011: return n != v;
         4'b1100: return !z && (n == v);
         4'b1101: return z || (n != v);
         4'b1110: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_counters(input string tag);
      check_eq({tag, "_exec"},   32'(exec_cnt),   32'(exp_exec));
      check_eq({tag, "_squash"}, 32'(squash_cnt), 32'(exp_squash));
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
      exp_exec = '0; exp_squash = '0;

      // 1: reset wins over a valid, flag-writing instruction
      #2;
      step();
      step();
      check_eq("rst_flags", 32'(Flags), 32'h0);
      check_counters("rst");

      // 2: AL with FlagW=10 sets N,Z; then EQ passes
      reset = 1'b0; Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b0100; en = 1'b1;
      #1;
      check_eq("t2_condex_al", 32'(CondEx), 32'h1);
      step(); exp_exec++;
      check_eq("t2_flags", 32'(Flags), 32'h4);
      Cond = 4'b0000; RegW = 1'b1; FlagW = 2'b00;
      #1;
      check_eq("t2_regwrite", 32'(RegWrite), 32'h1);
      step(); exp_exec++;
      check_eq("t2_exec_two", 32'(exec_cnt), 32'h2);
      check_counters("t2");

      // 3: NE fails with Z=1 -> squashed, no flag write, no MemWrite
      RegW = 1'b0; MemW = 1'b1; Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b1011;
      #1;
      check_eq("t3_memwrite", 32'(MemWrite), 32'h0);
      check_eq("t3_condex", 32'(CondEx), 32'h0);
      step(); exp_squash++;
      check_eq("t3_flags", 32'(Flags), 32'h4);
      check_counters("t3");

      // 5: clear flags, then FlagW=01 writes only C,V
      MemW = 1'b0; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0000;
      step(); exp_exec++;
      check_eq("t5_clear", 32'(Flags), 32'h0);
      FlagW = 2'b01; ALUFlags = 4'b1111; PCS = 1'b1;
      #1;
      check_eq("t5_pcsrc_on", 32'(PCSrc), 32'h1);
      step(); exp_exec++;
      check_eq("t5_flags_cv", 32'(Flags), 32'h3);
      en = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1100;
      #1;
      check_eq("t5_pcsrc_off", 32'(PCSrc), 32'h0);
      check_eq("t5_condex_idle", 32'(CondEx), 32'h1);
      step();
      check_eq("t5_flags_held", 32'(Flags), 32'h3);
      check_counters("t5");
      PCS = 1'b0;

      // 4: load each flag value, then sweep every Cond code while idle
      for (int f = 0; f < 16; f++) begin
         en = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'(f);
         step(); exp_exec++;
         check_eq($sformatf("t4_load_%0h", f), 32'(Flags), 32'(f));
         en = 1'b0;
         for (int c = 0; c < 16; c++) begin
            Cond = 4'(c);
            #1;
            check_eq($sformatf("t4_c%0h_f%0h", c, f), 32'(CondEx),
                     32'(cond_ref(4'(c), 4'(f))));
         end
      end
      step();
      check_counters("t4");

      // 6: run exec_cnt up to all-ones, then wrap
      en = 1'b1; Cond = 4'b1110; FlagW = 2'b00;
      while (exp_exec != {CNT_W{1'b1}}) begin
         step(); exp_exec++;
      end
      check_eq("t6_all_ones", 32'(exec_cnt), 32'(4'hF));
      step(); exp_exec++;
      check_eq("t6_wrap", 32'(exec_cnt), 32'h0);
      check_counters("t6");

      // Mid-instruction reset discards that instruction's effects
      FlagW = 2'b11; ALUFlags = 4'b0101; reset = 1'b1;
      step();
      exp_exec = '0; exp_squash = '0;
      check_eq("midrst_flags", 32'(Flags), 32'h0);
      check_counters("midrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
